// File: rtl/vtisa_pkg.sv
// Shared ISA definitions for the fetch/decode front end and the executor.
// ILLEGAL_TRAP_EN adds the illegal flag to the decoded-instruction record.
package vtisa_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LI   = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_LD   = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b10000;

  // Instruction byte layout: opcode in the top five bits, imm/register below.
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 3;
  localparam int ARG_HI = 2;
  localparam int ARG_LO = 0;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FETCH      = 2'd1;
  localparam logic [1:0] ST_FETCH_KILL = 2'd2;
  localparam logic [1:0] ST_ISSUE      = 2'd3;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] imm;
    logic [2:0] register;
    logic       is_alu_op;
    logic       is_mem_op;
    logic       mem_rw;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one instruction byte into fields and class flags.
// ILLEGAL_TRAP_EN: undefined opcodes flag illegal instead of becoming NOP.
module instr_decode
  import vtisa_pkg::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  logic [4:0] op;
  assign op = ir[OPC_HI:OPC_LO];

  always_comb begin
    dec          = '0;
    dec.opcode   = op;
    dec.imm      = ir[ARG_HI:ARG_LO];
    dec.register = ir[ARG_HI:ARG_LO];
    case (op)
      OP_LI, OP_ADDI: dec.is_alu_op = 1'b1;
      OP_LD:          dec.is_mem_op = 1'b1;
      OP_ST: begin
        dec.is_mem_op = 1'b1;
        dec.mem_rw    = 1'b1;
      end
      OP_NOP, OP_JMP: ;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`else
        dec.opcode  = OP_NOP;
`endif
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch + decode front end: one outstanding fetch, registered issue.
// ILLEGAL_TRAP_EN adds the illegal output and stalls issue until a redirect.
module fetch_decode
  import vtisa_pkg::*;
#(
  parameter int BITS_IDX = 7
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [BITS_IDX:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [BITS_IDX:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS_IDX:0] pc,
  output logic [4:0]        opcode,
  output logic [2:0]        imm,
  output logic [2:0]        register,
`ifdef ILLEGAL_TRAP_EN
  output logic              illegal,
`endif
  output logic              is_alu_op,
  output logic              is_mem_op,
  output logic              mem_rw
);

  localparam logic [BITS_IDX:0] PC_ONE = {{BITS_IDX{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [BITS_IDX:0] fetch_pc;
  logic [BITS_IDX:0] npc;
  logic              take;
  dec_t              dec_w;
  dec_t              dec_q;

  instr_decode u_dec (
    .ir  (mem_rdata),
    .dec (dec_w)
  );

  // A redirect always wins over the sequential fetch PC.
  assign npc = redirect_valid ? redirect_pc : fetch_pc;

`ifdef ILLEGAL_TRAP_EN
  assign take    = out_ready && !dec_q.illegal;
  assign illegal = dec_q.illegal;
`else
  assign take    = out_ready;
`endif

  assign opcode    = dec_q.opcode;
  assign imm       = dec_q.imm;
  assign register  = dec_q.register;
  assign is_alu_op = dec_q.is_alu_op;
  assign is_mem_op = dec_q.is_mem_op;
  assign mem_rw    = dec_q.mem_rw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      fetch_pc  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      pc        <= '0;
      dec_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fetch_pc <= npc;
          mem_addr <= npc;
          mem_req  <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redirect_valid) begin
            // Data returning alongside a redirect is stale: refetch directly.
            fetch_pc <= redirect_pc;
            if (mem_ack) mem_addr <= redirect_pc;
            else         state    <= ST_FETCH_KILL;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            dec_q     <= dec_w;
            pc        <= mem_addr;
            fetch_pc  <= mem_addr + PC_ONE;
            out_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_FETCH_KILL: begin
          fetch_pc <= npc;
          if (mem_ack) begin
            mem_addr <= npc;
            state    <= ST_FETCH;
          end
        end
        ST_ISSUE: begin
          if (redirect_valid || take) begin
            out_valid <= 1'b0;
            mem_req   <= 1'b1;
            mem_addr  <= npc;
            fetch_pc  <= npc;
            state     <= ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            dec_q.illegal <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: bench acts as instruction memory and
// executor; issued instructions are checked against a scoreboard queue.
module tb_fetch_decode;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pc;
  logic [4:0] opcode;
  logic [2:0] imm;
  logic [2:0] register;
  logic       is_alu_op;
  logic       is_mem_op;
  logic       mem_rw;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] pc;
    logic [4:0] opcode;
    logic [2:0] imm;
    logic [2:0] register;
    logic       alu;
    logic       mem;
    logic       rw;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  fetch_decode #(.BITS_IDX(7)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc             (pc),
    .opcode         (opcode),
    .imm            (imm),
    .register       (register),
`ifdef ILLEGAL_TRAP_EN
    .illegal        (illegal),
`endif
    .is_alu_op      (is_alu_op),
    .is_mem_op      (is_mem_op),
    .mem_rw         (mem_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] ir);
    exp_t e;
    e.pc = a; e.opcode = ir[7:3]; e.imm = ir[2:0]; e.register = ir[2:0];
    e.alu = 1'b0; e.mem = 1'b0; e.rw = 1'b0; e.ill = 1'b0;
    case (ir[7:3])
      5'b00001, 5'b00010: e.alu = 1'b1;
      5'b01000: e.mem = 1'b1;
      5'b01001: begin e.mem = 1'b1; e.rw = 1'b1; end
      5'b00000, 5'b10000: ;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        e.ill = 1'b1;
`else
        e.opcode = 5'b00000;
`endif
      end
    endcase
    return e;
  endfunction

  // Called at a negedge while a fetch is pending; acks it zero-wait.
  task automatic ack_fetch(input string tag, input logic [7:0] a, input logic [7:0] ir);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, a);
    mem_ack = 1'b1; mem_rdata = ir;
    sb.push_back(model(a, ir));
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic check_issue(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    chk({tag, "_valid"}, out_valid, 1);
    if (sb.size() != 0) begin
      e = sb[0];
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_opcode"}, opcode, e.opcode);
      chk({tag, "_imm"}, imm, e.imm);
      chk({tag, "_register"}, register, e.register);
      chk({tag, "_flags"}, {is_alu_op, is_mem_op, mem_rw}, {e.alu, e.mem, e.rw});
`ifdef ILLEGAL_TRAP_EN
      chk({tag, "_illegal"}, illegal, e.ill);
`endif
    end
  endtask

  task automatic pop();
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {pc, opcode, imm, register, is_alu_op, is_mem_op, mem_rw}, 0);

    // Reset release, immediate ack of LI r5 at PC 0
    reset = 1'b1;
    @(negedge clk);
    chk("start_out_valid", out_valid, 0);
    ack_fetch("li0", 8'h00, 8'h0D);
    check_issue("li0");
    chk("li0_opcode_li", opcode, 5'b00001);
    chk("li0_imm5", imm, 3'd5);
    chk("li0_no_req", mem_req, 0);

    // Executor stalls four cycles: fields hold, no new fetch
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_issue("stall");
      chk("stall_no_req", mem_req, 0);
    end
    out_ready = 1'b1;
    pop();
    @(negedge clk);
    chk("after_take_valid", out_valid, 0);
    ack_fetch("st1", 8'h01, 8'h4B);
    check_issue("st1");
    pop();

    // Redirect to 0x40 while fetch of PC 2 is outstanding
    @(negedge clk);
    chk("pre_kill_addr", mem_addr, 8'h02);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("kill_req", mem_req, 1);
      chk("kill_addr_stable", mem_addr, 8'h02);
      chk("kill_no_valid", out_valid, 0);
      if (i == 0) @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 8'h0D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("kill_discard_valid", out_valid, 0);
    ack_fetch("ld40", 8'h40, 8'h43);
    check_issue("ld40");
    pop();

    // Redirect during ISSUE with executor not ready: instruction dropped
    @(negedge clk);
    ack_fetch("jmp41", 8'h41, 8'h80);
    check_issue("jmp41");
    pop();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'hFF;
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("iss_redir_valid", out_valid, 0);
    ack_fetch("li_ff", 8'hFF, 8'h0D);
    check_issue("li_ff");
    pop();

    // PC wraps 0xFF -> 0x00; then an undefined opcode
    @(negedge clk);
    ack_fetch("ill0", 8'h00, 8'hF8);
    check_issue("ill0");
`ifdef ILLEGAL_TRAP_EN
    chk("ill0_trap", illegal, 1);
    @(negedge clk);
    chk("ill0_stall_valid", out_valid, 1);
    chk("ill0_stall_illegal", illegal, 1);
    chk("ill0_stall_no_req", mem_req, 0);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    pop();
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("ill0_cleared", illegal, 0);
    chk("ill0_redir_addr", mem_addr, 8'h10);
`else
    chk("ill0_as_nop", {opcode, is_alu_op, is_mem_op, mem_rw}, 0);
    pop();
    @(negedge clk);
    chk("ill0_next_addr", mem_addr, 8'h01);
`endif
    chk("pre_rst_req", mem_req, 1);
    chk("pre_rst_valid", out_valid, 0);

    // Reset mid-fetch: request drops without waiting for a clock
    reset = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_pc", pc, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 0);

    // Redirect coinciding with ack: data discarded, refetch at 0x20
    mem_ack = 1'b1; mem_rdata = 8'h0D; redirect_valid = 1'b1; redirect_pc = 8'h20;
    @(negedge clk);
    mem_ack = 1'b0; redirect_valid = 1'b0;
    chk("redir_ack_valid", out_valid, 0);
    ack_fetch("addi20", 8'h20, 8'h12);
    check_issue("addi20");
    pop();
    @(negedge clk);
    chk("final_valid", out_valid, 0);
    chk("final_addr", mem_addr, 8'h21);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter BITS_IDX, default 7, MSB index of PC and memory address (PC width BITS_IDX+1).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports mem_req output 1, mem_addr output BITS_IDX+1, mem_ack input 1, mem_rdata input 8: instruction-fetch handshake.
REQ-005 SHALL have ports redirect_valid input 1, redirect_pc input BITS_IDX+1: control-flow redirect from execute.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1: issue handshake to the executor.
REQ-007 SHALL have outputs pc BITS_IDX+1, opcode 5, imm 3, register 3, is_alu_op 1, is_mem_op 1, mem_rw 1: decoded instruction fields, all registered.

Function
REQ-008 SHALL decode instruction byte as opcode=ir[7:3], imm=ir[2:0], register=ir[2:0].
REQ-009 SHALL use opcodes OP_NOP=00000, OP_LI=00001, OP_ADDI=00010, OP_LD=01000, OP_ST=01001, OP_JMP=10000.
REQ-010 SHALL set is_alu_op=1 for LI/ADDI, is_mem_op=1 for LD/ST, mem_rw=1 only for ST, else 0.
REQ-011 SHALL implement FSM states IDLE, FETCH, FETCH_KILL, ISSUE.
REQ-012 SHALL transition IDLE->FETCH unconditionally one cycle after reset release.
REQ-013 SHALL, on entering FETCH, load mem_addr from fetch PC and hold mem_req=1 with mem_addr stable until mem_ack sampled high.
REQ-014 SHALL, on mem_ack in FETCH, latch mem_rdata, present decoded fields with pc = fetch address, drop mem_req, increment fetch PC modulo 2^(BITS_IDX+1) (wrap max->0), enter ISSUE; one fetch per two cycles minimum with zero-wait ack.
REQ-015 SHALL hold out_valid=1 and all fields stable in ISSUE until out_ready=1; handshake completes on the cycle both are high, then FETCH.
REQ-016 SHALL, on redirect_valid in ISSUE, drop out_valid next cycle, load fetch PC with redirect_pc, enter FETCH; if out_ready is also high that cycle the instruction counts as consumed.
REQ-017 SHALL, on redirect_valid in FETCH without mem_ack, load fetch PC with redirect_pc, keep request unchanged, enter FETCH_KILL; on redirect_valid with mem_ack same cycle, discard data and re-enter FETCH at redirect_pc.
REQ-018 SHALL in FETCH_KILL hold mem_req until mem_ack, discard mem_rdata, then enter FETCH; a further redirect there overwrites fetch PC.
REQ-019 SHALL ignore redirect_valid in IDLE except loading fetch PC.

Reset
REQ-020 SHALL on reset asserted force state IDLE, fetch PC=0, mem_req=0, mem_addr=0, out_valid=0, all decoded outputs 0, regardless of in-flight transaction.
REQ-021 SHALL abandon any pending mem_req on reset; memory side sees mem_req fall asynchronously.

Configuration
REQ-022 SHALL, with ILLEGAL_TRAP_EN defined, add output illegal (1) set in ISSUE for opcodes outside REQ-009, decoded flags 0, and stall in ISSUE until redirect_valid (out_ready ignored).
REQ-023 SHALL, without ILLEGAL_TRAP_EN, decode undefined opcodes as OP_NOP with all flags 0 and no illegal port.

Structure
REQ-024 SHALL place opcode constants, FSM state encodings and instruction field positions in shared package vtisa_pkg, also used by the executor.
REQ-025 SHALL implement decoding as combinational sub-module instr_decode (8-bit in, fields and flags out); fetch_decode registers its outputs.

Verification
REQ-026 SHALL cover: reset release, mem_ack immediate, rdata 0x0D -> mem_addr=0, out_valid cycle 3, opcode=OP_LI, imm=5, is_alu_op=1, pc=0.
REQ-027 SHALL cover: out_ready low 4 cycles in ISSUE -> fields stable, no mem_req; out_ready high -> next mem_addr=1.
REQ-028 SHALL cover: redirect_pc=0x40 in FETCH, mem_ack 3 cycles later -> data discarded, out_valid stays 0, next mem_addr=0x40.
REQ-029 SHALL cover: fetch at PC 0xFF -> next mem_addr=0x00.
REQ-030 SHALL cover: reset asserted mid-FETCH with mem_req high -> mem_req, out_valid 0 immediately; restart at mem_addr=0.
REQ-031 SHALL cover: rdata 0xF8 -> with ILLEGAL_TRAP_EN illegal=1 until redirect; without, decoded NOP, flags 0.
